// File: rtl/life_video_pkg.sv
// Shared constants, stage record and output packing for the Game-of-Life video pipe.
package life_video_pkg;

    localparam int unsigned DEF_LOG_W  = 6;
    localparam int unsigned DEF_LOG_H  = 5;
    localparam int unsigned DEF_WIN_X0 = 64;
    localparam int unsigned DEF_WIN_Y0 = 112;

    // Colours are {R[1:0], G[1:0], B[1:0]}
    localparam logic [5:0] COL_BLANK  = 6'b00_00_00;
    localparam logic [5:0] COL_BG     = 6'b00_00_01;
    localparam logic [5:0] COL_DEAD   = 6'b01_01_01;
    localparam logic [5:0] COL_LIVE   = 6'b11_11_01;
    localparam logic [5:0] COL_CURSOR = 6'b11_00_00;

    // Row 0 in the top byte; within a byte the MSB is icon column 0
    localparam logic [63:0] ICON_BITMAP = 64'h00_3C_7E_7E_7E_7E_3C_00;

    // Syncs are carried as "active" flags so a zeroed stage means inactive syncs
    typedef struct packed {
        logic       in_win;
        logic       display_on;
        logic [2:0] icon_x;
        logic [2:0] icon_y;
        logic       cursor_hit;
        logic       edge_flag;
        logic       hsync;
        logic       vsync;
    } pix_stage_t;

    function automatic logic [7:0] pack_uo(input logic [5:0] rgb, input logic hs_on,
                                           input logic vs_on, input logic hs_pol,
                                           input logic vs_pol);
        logic hs;
        logic vs;
        hs = hs_on ? hs_pol : ~hs_pol;
        vs = vs_on ? vs_pol : ~vs_pol;
        return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
    endfunction

endpackage

// File: rtl/life_video_pipe_if.sv
// Beam, board-read and pin-output bundle between the timing/board side and the video pipe.
interface life_video_pipe_if #(
    parameter int unsigned LOG_W = 6,
    parameter int unsigned LOG_H = 5
);
    logic [9:0]             hpos;
    logic [9:0]             vpos;
    logic                   display_on;
    logic                   hsync_in;
    logic                   vsync_in;
    logic [LOG_W-1:0]       cursor_x;
    logic [LOG_H-1:0]       cursor_y;
    logic                   cursor_en;
    logic [LOG_W+LOG_H-1:0] cell_addr;
    logic                   cell_rd_data;
    logic [7:0]             uo_pack;
    logic                   frame_tick;
    logic [15:0]            frame_count;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in,
        output cursor_x, cursor_y, cursor_en, cell_rd_data,
        input  cell_addr, uo_pack, frame_tick, frame_count
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in,
        input  cursor_x, cursor_y, cursor_en, cell_rd_data,
        output cell_addr, uo_pack, frame_tick, frame_count
    );
endinterface

// File: rtl/life_icon_rom.sv
// 8x8 cell icon lookup; constant ROM, no state.
module life_icon_rom
    import life_video_pkg::*;
(
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);
    // Bit index 63 - 8*row - col, i.e. the bitwise complement of {row, col}
    assign pixel = ICON_BITMAP[{~row, ~col}];
endmodule

// File: rtl/life_video_pipe.sv
// Three-stage pixel renderer for the Life board, plus vsync frame tick and frame counter.
module life_video_pipe
    import life_video_pkg::*;
#(
    parameter int unsigned LOG_W     = DEF_LOG_W,
    parameter int unsigned LOG_H     = DEF_LOG_H,
    parameter int unsigned WIN_X0    = DEF_WIN_X0,
    parameter int unsigned WIN_Y0    = DEF_WIN_Y0,
    parameter logic        VSYNC_ACT = 1'b0,
    parameter logic        HSYNC_ACT = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    life_video_pipe_if.slave bus
);
    localparam int unsigned WIN_W = 32'd8 << LOG_W;
    localparam int unsigned WIN_H = 32'd8 << LOG_H;

    logic [9:0]             lx;
    logic [9:0]             ly;
    logic                   in_win;
    logic [LOG_W-1:0]       col;
    logic [LOG_H-1:0]       row;
    pix_stage_t             s0_next;
    pix_stage_t             s0;
    pix_stage_t             s1;
    logic [LOG_W+LOG_H-1:0] cell_addr_q;
    logic                   icon_bit;
    logic [5:0]             rgb;
    logic [7:0]             uo_q;
    logic                   vs_now;
    logic                   vs_prev;
    logic                   primed;
    logic                   vs_rise;
    logic                   tick_q;
    logic [15:0]            frame_cnt;

    assign lx  = bus.hpos - 10'(WIN_X0);
    assign ly  = bus.vpos - 10'(WIN_Y0);
    assign col = lx[LOG_W+2:3];
    assign row = ly[LOG_H+2:3];

    // Lower bound on the raw position, upper bound on the offset (wraps when below)
    assign in_win = (32'(bus.hpos) >= WIN_X0) && (32'(lx) < WIN_W) &&
                    (32'(bus.vpos) >= WIN_Y0) && (32'(ly) < WIN_H);

    always_comb begin
        s0_next            = '0;
        s0_next.in_win     = in_win;
        s0_next.display_on = bus.display_on;
        s0_next.icon_x     = lx[2:0];
        s0_next.icon_y     = ly[2:0];
        s0_next.cursor_hit = bus.cursor_en && (row == bus.cursor_y) && (col == bus.cursor_x);
        s0_next.edge_flag  = (lx[2:0] == 3'd0) || (lx[2:0] == 3'd7) ||
                             (ly[2:0] == 3'd0) || (ly[2:0] == 3'd7);
        s0_next.hsync      = (bus.hsync_in == HSYNC_ACT);
        s0_next.vsync      = (bus.vsync_in == VSYNC_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0          <= '0;
            s1          <= '0;
            cell_addr_q <= '0;
        end else begin
            s0 <= s0_next;
            s1 <= s0;
            if (in_win) cell_addr_q <= {row, col};
        end
    end

    life_icon_rom u_icon (
        .row   (s1.icon_y),
        .col   (s1.icon_x),
        .pixel (icon_bit)
    );

    always_comb begin
        rgb = COL_DEAD;
        if (!s1.display_on)                   rgb = COL_BLANK;
        else if (!s1.in_win)                  rgb = COL_BG;
        else if (s1.cursor_hit && s1.edge_flag) rgb = COL_CURSOR;
        else if (bus.cell_rd_data && icon_bit) rgb = COL_LIVE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) uo_q <= pack_uo(COL_BLANK, 1'b0, 1'b0, HSYNC_ACT, VSYNC_ACT);
        else        uo_q <= pack_uo(rgb, s1.hsync, s1.vsync, HSYNC_ACT, VSYNC_ACT);
    end

    // primed suppresses a tick when vsync is already active as reset releases
    assign vs_now  = (bus.vsync_in == VSYNC_ACT);
    assign vs_rise = primed && vs_now && !vs_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            primed    <= 1'b0;
            vs_prev   <= 1'b0;
            tick_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            primed  <= 1'b1;
            vs_prev <= vs_now;
            tick_q  <= vs_rise;
            if (vs_rise) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign bus.cell_addr   = cell_addr_q;
    assign bus.uo_pack     = uo_q;
    assign bus.frame_tick  = tick_q;
    assign bus.frame_count = frame_cnt;

endmodule

// File: tb/tb_life_video_pipe.sv
// Directed vectors for life_video_pipe with hand-computed uo_pack values (default polarities).
module tb_life_video_pipe;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    // uo_pack with syncs inactive: {hs,B0,G0,R0,vs,B1,G1,R1}
    localparam logic [7:0] P_BLANK  = 8'h88;
    localparam logic [7:0] P_BG     = 8'hC8;
    localparam logic [7:0] P_DEAD   = 8'hF8;
    localparam logic [7:0] P_LIVE   = 8'hFB;
    localparam logic [7:0] P_CURSOR = 8'h99;

    life_video_pipe_if #(.LOG_W(6), .LOG_H(5)) bus ();

    life_video_pipe #(
        .LOG_W(6), .LOG_H(5), .WIN_X0(64), .WIN_Y0(112),
        .VSYNC_ACT(1'b0), .HSYNC_ACT(1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic d_on);
        bus.hpos       = 10'(x);
        bus.vpos       = 10'(y);
        bus.display_on = d_on;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        bus.hpos = '0; bus.vpos = '0; bus.display_on = 1'b0;
        bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        bus.cursor_x = '0; bus.cursor_y = '0; bus.cursor_en = 1'b0;
        bus.cell_rd_data = 1'b0;
        step(); step();
        chk("reset_uo", 32'(bus.uo_pack), 32'(P_BLANK));
        chk("reset_addr", 32'(bus.cell_addr), 32'h0);
        chk("reset_tick", 32'(bus.frame_tick), 32'h0);
        chk("reset_count", 32'(bus.frame_count), 32'h0);
        rst_n = 1'b1;

        // window corner: icon row 0 is blank even when alive
        pix(64, 112, 1'b1);
        step();
        chk("corner_addr", 32'(bus.cell_addr), 32'h000);
        step(); bus.cell_rd_data = 1'b1;
        step();
        chk("corner_dead", 32'(bus.uo_pack), 32'(P_DEAD));

        // cell (row 2, col 5), icon (3,3)
        pix(107, 131, 1'b1);
        step();
        chk("cell_addr_085", 32'(bus.cell_addr), 32'h085);
        step(); bus.cell_rd_data = 1'b1;
        step();
        chk("alive_live", 32'(bus.uo_pack), 32'(P_LIVE));
        bus.cell_rd_data = 1'b0;
        step();
        chk("dead_cell", 32'(bus.uo_pack), 32'(P_DEAD));

        // cursor on cell (5,2)
        bus.cursor_en = 1'b1; bus.cursor_x = 6'd5; bus.cursor_y = 5'd2;
        bus.cell_rd_data = 1'b1;
        pix(104, 128, 1'b1);
        step(); step(); step();
        chk("cursor_edge", 32'(bus.uo_pack), 32'(P_CURSOR));
        pix(107, 131, 1'b1);
        step(); step(); step();
        chk("cursor_inner", 32'(bus.uo_pack), 32'(P_LIVE));
        bus.cursor_x = 6'd6;
        pix(104, 128, 1'b1);
        step(); step(); step();
        chk("cursor_other_cell", 32'(bus.uo_pack), 32'(P_DEAD));
        bus.cursor_x = 6'd5; bus.cursor_en = 1'b0;
        step(); step(); step();
        chk("cursor_off", 32'(bus.uo_pack), 32'(P_DEAD));

        // outside window, then blanking; address holds outside the window
        pix(600, 200, 1'b1);
        step();
        chk("addr_hold", 32'(bus.cell_addr), 32'h085);
        step(); step();
        chk("outside_bg", 32'(bus.uo_pack), 32'(P_BG));
        pix(600, 200, 1'b0);
        step(); step(); step();
        chk("blank", 32'(bus.uo_pack), 32'(P_BLANK));

        // hsync one-cycle pulse appears 3 edges later
        bus.hsync_in = 1'b0;
        step();
        chk("hs_d0", 32'(bus.uo_pack), 32'h88);
        bus.hsync_in = 1'b1;
        step();
        chk("hs_d1", 32'(bus.uo_pack), 32'h88);
        step();
        chk("hs_d2", 32'(bus.uo_pack), 32'h08);
        step();
        chk("hs_d3", 32'(bus.uo_pack), 32'h88);

        // three vsync pulses, two cycles active each
        for (int p = 0; p < 3; p++) begin
            bus.vsync_in = 1'b0;
            step();
            chk("vs_tick_hi", 32'(bus.frame_tick), 32'h1);
            chk("vs_count", 32'(bus.frame_count), 32'(p + 1));
            step();
            chk("vs_tick_lo", 32'(bus.frame_tick), 32'h0);
            bus.vsync_in = 1'b1;
            step();
            chk("vs_out_a", 32'(bus.uo_pack), 32'h80);
            chk("vs_tick_lo2", 32'(bus.frame_tick), 32'h0);
            step();
            chk("vs_out_b", 32'(bus.uo_pack), 32'h80);
            step();
            chk("vs_out_c", 32'(bus.uo_pack), 32'h88);
        end
        chk("count_3", 32'(bus.frame_count), 32'h3);

        // preset counter to FFFF, next tick wraps
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        chk("count_preset", 32'(bus.frame_count), 32'hFFFF);
        bus.vsync_in = 1'b0;
        step();
        chk("wrap_tick", 32'(bus.frame_tick), 32'h1);
        chk("wrap_count", 32'(bus.frame_count), 32'h0000);
        bus.vsync_in = 1'b1;
        step(); step(); step();

        // mid-line reset
        pix(107, 131, 1'b1);
        bus.cell_rd_data = 1'b1;
        step(); step(); step();
        chk("pre_reset_live", 32'(bus.uo_pack), 32'(P_LIVE));
        rst_n = 1'b0;
        step();
        chk("rst_uo", 32'(bus.uo_pack), 32'h88);
        chk("rst_count", 32'(bus.frame_count), 32'h0);
        chk("rst_addr", 32'(bus.cell_addr), 32'h0);
        rst_n = 1'b1;
        step();
        chk("rel_addr", 32'(bus.cell_addr), 32'h085);
        chk("rel_uo1", 32'(bus.uo_pack), 32'(P_BLANK));
        step();
        chk("rel_uo2", 32'(bus.uo_pack), 32'(P_BLANK));
        step();
        chk("rel_uo3", 32'(bus.uo_pack), 32'(P_LIVE));

        // vsync already active across reset release: no tick until next edge
        bus.vsync_in = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("held_vs_tick0", 32'(bus.frame_tick), 32'h0);
        step();
        chk("held_vs_tick1", 32'(bus.frame_tick), 32'h0);
        bus.vsync_in = 1'b1;
        step();
        bus.vsync_in = 1'b0;
        step();
        chk("next_edge_tick", 32'(bus.frame_tick), 32'h1);
        chk("next_edge_count", 32'(bus.frame_count), 32'h1);
        step();
        chk("next_edge_once", 32'(bus.frame_tick), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
